// File: rtl/serial_logic_alu.sv
//==============================================================================
// Module   : serial_logic_alu (with and_gate / or_gate / xor_gate primitives)
// Purpose  : Bit-serial AND/OR/XOR/ADD unit, LSB first, valid/ready on both sides.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module and_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & i_b;
endmodule

module or_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a | i_b;
endmodule

module xor_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a ^ i_b;
endmodule

module serial_logic_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);
    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);
    localparam logic [1:0]       c_OP_AND = 2'b00;
    localparam logic [1:0]       c_OP_OR  = 2'b01;
    localparam logic [1:0]       c_OP_XOR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;

    logic             w_and_ab;
    logic             w_or_ab;
    logic             w_xor_ab;
    logic             w_sum;
    logic             w_and_cx;
    logic             w_carry_nxt;
    logic             w_bit;
    logic [WIDTH-1:0] w_acc_nxt;

    // One bit slice: the logic ops reuse the full-adder's first-level gates.
    and_gate u_and_ab  (.i_a(r_a[0]),   .i_b(r_b[0]),   .o_y(w_and_ab));
    or_gate  u_or_ab   (.i_a(r_a[0]),   .i_b(r_b[0]),   .o_y(w_or_ab));
    xor_gate u_xor_ab  (.i_a(r_a[0]),   .i_b(r_b[0]),   .o_y(w_xor_ab));
    xor_gate u_xor_sum (.i_a(w_xor_ab), .i_b(r_carry),  .o_y(w_sum));
    and_gate u_and_cx  (.i_a(r_carry),  .i_b(w_xor_ab), .o_y(w_and_cx));
    or_gate  u_or_cy   (.i_a(w_and_ab), .i_b(w_and_cx), .o_y(w_carry_nxt));

    always_comb begin
        w_bit = w_sum;
        case (r_op)
            c_OP_AND: w_bit = w_and_ab;
            c_OP_OR:  w_bit = w_or_ab;
            c_OP_XOR: w_bit = w_xor_ab;
            default:  w_bit = w_sum;
        endcase
    end

    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_nxt = w_bit;
        end else begin : g_acc_wn
            assign w_acc_nxt = {w_bit, r_acc[WIDTH-1:1]};
        end
    endgenerate

    // The accumulator is private; result only updates on the final bit so the
    // previous answer stays visible until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= 2'b00;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_acc     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_op     <= op;
                        r_cnt    <= '0;
                        r_carry  <= 1'b0;
                        in_ready <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_nxt;
                    r_cnt   <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        result    <= w_acc_nxt;
                        carry_out <= (r_op == 2'b11) ? w_carry_nxt : 1'b0;
                        zero      <= (w_acc_nxt == '0);
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_serial_logic_alu.sv
//==============================================================================
// Module   : tb_serial_logic_alu
// Purpose  : Directed self-checking bench for serial_logic_alu at WIDTH 8, 1, 32.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_logic_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv8 = 0, ir8, ov8, or8 = 0, co8, z8;
    logic [7:0]  a8 = 0, b8 = 0, res8;
    logic [1:0]  op8 = 0;
    logic        iv1 = 0, ir1, ov1, or1 = 0, co1, z1;
    logic [0:0]  a1 = 0, b1 = 0, res1;
    logic [1:0]  op1 = 0;
    logic        iv32 = 0, ir32, ov32, or32 = 0, co32, z32;
    logic [31:0] a32 = 0, b32 = 0, res32;
    logic [1:0]  op32 = 0;

    int checks = 0;
    int failures = 0;

    serial_logic_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
        .out_valid(ov8), .out_ready(or8), .result(res8), .carry_out(co8), .zero(z8));
    serial_logic_alu #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .op(op1),
        .out_valid(ov1), .out_ready(or1), .result(res1), .carry_out(co1), .zero(z1));
    serial_logic_alu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .op(op32),
        .out_valid(ov32), .out_ready(or32), .result(res32), .carry_out(co32), .zero(z32));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
        case (o)
            2'b00:   return {1'b0, x & y};
            2'b01:   return {1'b0, x | y};
            2'b10:   return {1'b0, x ^ y};
            default: return {1'b0, x} + {1'b0, y};
        endcase
    endfunction

    // Present one op, wait (bounded) for out_valid; leaves the DUT in DONE.
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_b, input logic [1:0] top,
                          output int lat, output logic [7:0] r, output logic c, output logic z);
        iv8 = 1; a8 = ta; b8 = tb_b; op8 = top; or8 = 0;
        step();
        iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
        lat = 0;
        while (!ov8 && lat < 40) begin step(); lat++; end
        r = res8; c = co8; z = z8;
    endtask

    task automatic do_op1(input logic ta, input logic tb_b, input logic [1:0] top,
                          output int lat, output logic r, output logic c, output logic z);
        iv1 = 1; a1 = ta; b1 = tb_b; op1 = top; or1 = 0;
        step();
        iv1 = 0; a1 = ~ta; b1 = ~tb_b;
        lat = 0;
        while (!ov1 && lat < 40) begin step(); lat++; end
        r = res1[0]; c = co1; z = z1;
        or1 = 1; step(); or1 = 0;
    endtask

    task automatic do_op32(input logic [31:0] ta, input logic [31:0] tb_b, input logic [1:0] top,
                           output int lat, output logic [31:0] r, output logic c, output logic z);
        iv32 = 1; a32 = ta; b32 = tb_b; op32 = top; or32 = 0;
        step();
        iv32 = 0; a32 = $urandom; b32 = $urandom;
        lat = 0;
        while (!ov32 && lat < 60) begin step(); lat++; end
        r = res32; c = co32; z = z32;
        or32 = 1; step(); or32 = 0;
    endtask

    task automatic drain8();
        or8 = 1; step(); or8 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        step(); step();
        checks++;
        if ({ir8, ov8, res8, co8, z8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset8 got rdy=%b vld=%b res=%h c=%b z=%b exp 1 0 00 0 0", ir8, ov8, res8, co8, z8);
        end
        checks++;
        if ({ir1, ov1, res1, co1, z1, ir32, ov32, res32, co32, z32} !== {4'b1000, 1'b0, 2'b10, 32'h0, 2'b00}) begin
            failures++;
            $display("FAIL reset_w1_w32 got %b %b %h %b %b / %b %b %h %b %b", ir1, ov1, res1, co1, z1, ir32, ov32, res32, co32, z32);
        end
        @(negedge clk); rst_n = 1;
        step();
    endtask

    task automatic test_or();
        int lat; logic [7:0] r; logic c, z;
        do_op8(8'hA5, 8'h0F, 2'b01, lat, r, c, z);
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL or_latency got=%0d exp=8", lat); end
        checks++;
        if ({r, c, z} !== {8'hAF, 1'b0, 1'b0}) begin
            failures++; $display("FAIL or_result got res=%h c=%b z=%b exp res=af c=0 z=0", r, c, z);
        end
        drain8();
        checks++;
        if ({ir8, ov8} !== 2'b10) begin failures++; $display("FAIL or_drain got rdy=%b vld=%b exp 1 0", ir8, ov8); end
    endtask

    task automatic test_add();
        int lat; logic [7:0] r; logic c, z;
        do_op8(8'hFF, 8'h01, 2'b11, lat, r, c, z);
        checks++;
        if ({r, c, z} !== {8'h00, 1'b1, 1'b1}) begin
            failures++; $display("FAIL add_ovf got res=%h c=%b z=%b exp res=00 c=1 z=1", r, c, z);
        end
        drain8();
        do_op8(8'h3C, 8'h47, 2'b11, lat, r, c, z);
        checks++;
        if ({r, c, z} !== {8'h83, 1'b0, 1'b0} || lat !== 8) begin
            failures++; $display("FAIL add_nocarry got res=%h c=%b z=%b lat=%0d exp res=83 c=0 z=0 lat=8", r, c, z, lat);
        end
        drain8();
    endtask

    task automatic test_and_xor();
        int lat; logic [7:0] r; logic c, z;
        do_op8(8'hFF, 8'hFF, 2'b11, lat, r, c, z);
        drain8();
        do_op8(8'hF0, 8'h0F, 2'b00, lat, r, c, z);
        checks++;
        if ({r, c, z} !== {8'h00, 1'b0, 1'b1}) begin
            failures++; $display("FAIL and_zero got res=%h c=%b z=%b exp res=00 c=0 z=1", r, c, z);
        end
        drain8();
        do_op8(8'h5A, 8'h5A, 2'b10, lat, r, c, z);
        checks++;
        if ({r, c, z} !== {8'h00, 1'b0, 1'b1}) begin
            failures++; $display("FAIL xor_zero got res=%h c=%b z=%b exp res=00 c=0 z=1", r, c, z);
        end
        drain8();
    endtask

    task automatic test_backpressure();
        int lat;
        iv8 = 1; a8 = 8'h33; b8 = 8'h55; op8 = 2'b10; or8 = 0;
        step();
        iv8 = 0;
        step();
        iv8 = 1; a8 = 8'hAA; b8 = 8'hAA; op8 = 2'b11;
        step();
        checks++;
        if (ir8 !== 1'b0) begin failures++; $display("FAIL run_ignore got rdy=%b exp 0", ir8); end
        iv8 = 0;
        lat = 0;
        while (!ov8 && lat < 40) begin step(); lat++; end
        checks++;
        if ({ov8, res8} !== {1'b1, 8'h66}) begin
            failures++; $display("FAIL bp_result got vld=%b res=%h exp vld=1 res=66", ov8, res8);
        end
        for (int k = 0; k < 5; k++) begin
            iv8 = (k == 2);
            step();
            checks++;
            if ({ov8, ir8, res8} !== {1'b1, 1'b0, 8'h66}) begin
                failures++; $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b res=%h exp 1 0 66", k, ov8, ir8, res8);
            end
        end
        iv8 = 1; a8 = 8'h0F; b8 = 8'hF0; op8 = 2'b01; or8 = 1;
        step();
        or8 = 0;
        checks++;
        if ({ir8, ov8, res8} !== {1'b1, 1'b0, 8'h66}) begin
            failures++; $display("FAIL done_exit got rdy=%b vld=%b res=%h exp 1 0 66", ir8, ov8, res8);
        end
        step();
        iv8 = 0;
        checks++;
        if (ir8 !== 1'b0) begin failures++; $display("FAIL next_accept got rdy=%b exp 0", ir8); end
        lat = 0;
        while (!ov8 && lat < 40) begin step(); lat++; end
        checks++;
        if ({res8, co8, z8} !== {8'hFF, 1'b0, 1'b0} || lat !== 8) begin
            failures++; $display("FAIL post_bp_op got res=%h c=%b z=%b lat=%0d exp ff 0 0 8", res8, co8, z8, lat);
        end
        drain8();
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] r; logic c, z;
        iv8 = 1; a8 = 8'h12; b8 = 8'h34; op8 = 2'b11;
        step();
        iv8 = 0;
        step(); step(); step();
        #2 rst_n = 0;
        #1;
        checks++;
        if ({ir8, ov8, res8, co8, z8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_mid got rdy=%b vld=%b res=%h c=%b z=%b exp 1 0 00 0 0", ir8, ov8, res8, co8, z8);
        end
        @(negedge clk); rst_n = 1;
        step();
        do_op8(8'h0F, 8'hFF, 2'b10, lat, r, c, z);
        checks++;
        if ({r, c, z} !== {8'hF0, 1'b0, 1'b0} || lat !== 8) begin
            failures++; $display("FAIL after_reset_xor got res=%h c=%b z=%b lat=%0d exp f0 0 0 8", r, c, z, lat);
        end
        drain8();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta, tbb; logic [1:0] top; logic [8:0] exp; int cnt;
        ta = 8'($urandom); tbb = 8'($urandom); top = 2'($urandom);
        iv8 = 1; or8 = 1; a8 = ta; b8 = tbb; op8 = top;
        for (int i = 0; i < 20; i++) begin
            cnt = 0;
            do begin step(); cnt++; end while (!ov8 && cnt < 30);
            exp = model8(ta, tbb, top);
            checks++;
            if ({co8, res8, z8} !== {exp, exp[7:0] == 8'h00} || cnt !== ((i == 0) ? 9 : 10)) begin
                failures++;
                $display("FAIL b2b[%0d] a=%h b=%h op=%b got res=%h c=%b z=%b gap=%0d exp res=%h c=%b gap=%0d",
                         i, ta, tbb, top, res8, co8, z8, cnt, exp[7:0], exp[8], (i == 0) ? 9 : 10);
            end
            ta = 8'($urandom); tbb = 8'($urandom); top = 2'($urandom);
            a8 = ta; b8 = tbb; op8 = top;
            if (i == 19) iv8 = 0;
        end
        step();
        or8 = 0;
        checks++;
        if ({ir8, ov8} !== 2'b10) begin failures++; $display("FAIL b2b_end got rdy=%b vld=%b exp 1 0", ir8, ov8); end
    endtask

    task automatic test_width1();
        int lat; logic r, c, z;
        do_op1(1'b1, 1'b1, 2'b11, lat, r, c, z);
        checks++;
        if ({r, c, z} !== 3'b011 || lat !== 1) begin
            failures++; $display("FAIL w1_add got res=%b c=%b z=%b lat=%0d exp 0 1 1 1", r, c, z, lat);
        end
        do_op1(1'b1, 1'b0, 2'b01, lat, r, c, z);
        checks++;
        if ({r, c, z} !== 3'b100 || lat !== 1) begin
            failures++; $display("FAIL w1_or got res=%b c=%b z=%b lat=%0d exp 1 0 0 1", r, c, z, lat);
        end
        do_op1(1'b1, 1'b0, 2'b11, lat, r, c, z);
        checks++;
        if ({r, c, z} !== 3'b100) begin
            failures++; $display("FAIL w1_add2 got res=%b c=%b z=%b exp 1 0 0", r, c, z);
        end
    endtask

    task automatic test_width32();
        int lat; logic [31:0] r; logic c, z;
        do_op32(32'hFFFF_FFFF, 32'h0000_0001, 2'b11, lat, r, c, z);
        checks++;
        if ({r, c, z} !== {32'h0, 1'b1, 1'b1} || lat !== 32) begin
            failures++; $display("FAIL w32_add got res=%h c=%b z=%b lat=%0d exp 0 1 1 32", r, c, z, lat);
        end
        do_op32(32'h1234_5678, 32'hFFFF_0000, 2'b10, lat, r, c, z);
        checks++;
        if ({r, c, z} !== {32'hEDCB_5678, 1'b0, 1'b0} || lat !== 32) begin
            failures++; $display("FAIL w32_xor got res=%h c=%b z=%b lat=%0d exp edcb5678 0 0 32", r, c, z, lat);
        end
    endtask

    initial begin
        test_reset();
        test_or();
        test_add();
        test_and_xor();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        test_width32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
